irq_capture8: RTL and testbench
===============================

// Module: irq_capture8
// PURPOSE
//  Upstream event-capture stage for the 8-to-3 encoder path.
//  - Detects rising edges on 8 request lines and holds them in a pending register.
//  - Presents one pending request at a time as a registered 3-bit index with valid/ready.
//  - Highest index has priority; a request is cleared from pending only when it is delivered.
//  - Lets the consumer take one event per handshake; no event is lost while it stays pending.
// PARAMETERS
//  N      8  number of request lines (fixed at 8 in this revision)
//  IDX_W  3  index width, equals $clog2(N)
//  EDGE   1  1 = capture rising edges only; 0 = capture level (req high every cycle sets pending)
// PORTS
//  clk      in   1      single clock, all state updates on posedge
//  rst      in   1      asynchronous, active-high reset
//  en       in   1      capture enable; 0 = new edges ignored, draining continues
//  req      in   N      request lines, synchronous to clk
//  ready    in   1      consumer accepts idx this cycle when valid=1
//  valid    out  1      idx holds a delivered request
//  idx      out  IDX_W  index of delivered request (bit i -> i)
//  pending  out  N      current pending register (debug/status)
//  drop     out  1      1-cycle pulse: an edge hit a bit already pending and was merged
// BEHAVIOUR
//  Reset (async, rst=1): req_q=0, pending=0, valid=0, idx=0, drop=0, state=IDLE.
//  - Because req_q resets to 0, a req bit already high at reset release counts as an edge.
//  Edge detect: ev = EDGE ? (req & ~req_q) : req, where req_q is req registered every cycle.
//  - req_q updates every cycle regardless of en.
//  - Therefore en 0->1 while req is high does not create an event.
//  - cap = en ? ev : 0.
//  Output slot FSM:
//  - IDLE (valid=0): if pending!=0, load idx=highest set bit of pending, clear that bit, go HOLD.
//  - HOLD (valid=1): idx and valid stay stable until valid&ready.
//    - On the handshake: if pending (after this cycle's clear) != 0, reload in the same cycle.
//      This gives back-to-back throughput of 1 event per clock.
//    - Otherwise go IDLE, valid=0.
//  Pending update, per clock: pending_next = (pending & ~load_mask) | cap.
//  - A captured edge on the bit being loaded this cycle re-sets that bit; it counts as a new event, no drop.
//  - drop=1 for one cycle if (cap & pending & ~load_mask) != 0.
//  Latency: req rises before clock edge k -> pending set at k -> valid=1 at k+1 if the slot was free.
//  Load selection uses the registered pending only; a cap arriving in the same cycle waits one cycle.
//  Priority: bit 7 highest. A lower bit can starve while higher bits keep re-firing; this is accepted.
//  ready while valid=0 has no effect. valid never drops without a handshake, except on reset.
//  Reset mid-HOLD: valid falls immediately (async) and pending is cleared.
// STRUCTURE
//  Package irq_pkg holds:
//  - N, IDX_W localparams
//  - state typedef {IDLE, HOLD}
//  - function onehot_of(idx) returning the N-bit load mask
//  Sub-module prio_enc8: combinational, in[7:0] -> out[2:0] (highest set bit), any (in!=0).
//  All registers, the edge detect and the FSM live in irq_capture8.
// TESTING
//  1. Reset release with req=0, en=1, ready=1; pulse req=8'h04 for 1 cycle.
//     -> 2 cycles later valid=1, idx=2 for 1 cycle; pending=0 afterwards.
//  2. ready=0; req steps 8'h00 -> 8'h81.
//     -> valid=1, idx=7, pending=8'h01.
//     -> Raise ready: idx=7 then idx=0 on consecutive cycles, then valid=0.
//  3. en=0; pulse each req bit 0..7 in turn.
//     -> valid stays 0, pending stays 0.
//     -> Set en=1 with req=8'h10 held high: no event.
//  4. ready=0 with bit 3 pending; re-pulse req[3].
//     -> drop=1 for exactly 1 cycle; only one idx=3 is delivered.
//  5. HOLD with idx=5 and ready=1; fire a req[5] edge in the handshake cycle.
//     -> no drop; a second idx=5 is delivered on a later cycle.
//  6. Assert rst while valid=1 and pending=8'h3C.
//     -> valid=0, idx=0, pending=0 without waiting for a clock.

Source files
------------

// File: rtl/irq_capture8_pkg.sv
// Shared types and constants for the irq_capture8 event-capture stage.
package irq_pkg;

    localparam int N     = 8;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot mask with only the bit selected by idx set; used to clear the
    // request that is being loaded into the output slot.
    function automatic logic [N-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        logic [N-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/irq_capture8_if.sv
// Request/consumer bundle for irq_capture8; master is the capture stage,
// slave is whoever drives requests and consumes the delivered index.
interface irq_capture8_if;
    import irq_pkg::*;

    logic             en;
    logic [N-1:0]     req;
    logic             ready;
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     pending;
    logic             drop;

    modport master (
        input  en,
        input  req,
        input  ready,
        output valid,
        output idx,
        output pending,
        output drop
    );

    modport slave (
        output en,
        output req,
        output ready,
        input  valid,
        input  idx,
        input  pending,
        input  drop
    );

endinterface

// File: rtl/irq_capture8_prio_enc8.sv
// Highest-set-bit encoder: bit 7 wins; any flags a non-empty input.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N-1:0]     data_in,
    output logic [IDX_W-1:0] idx_out,
    output logic             any
);

    // Scan upward so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_out = '0;
        for (int i = 0; i < N; i++) begin
            if (data_in[i]) begin
                idx_out = IDX_W'(i);
            end
        end
        any = |data_in;
    end

endmodule

// File: rtl/irq_capture8.sv
// Edge-capture stage: rising edges on req set pending bits, and the highest
// pending bit is delivered one at a time through a registered valid/idx slot.
module irq_capture8
    import irq_pkg::*;
#(
    parameter bit EDGE = 1'b1
)
(
    input  logic           clk,
    input  logic           rst,
    irq_capture8_if.master bus
);

    state_t           state_q, state_d;
    logic [N-1:0]     req_q, req_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drop_q, drop_d;

    logic [N-1:0]     ev;
    logic [N-1:0]     cap;
    logic [N-1:0]     load_mask;
    logic             load;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    // Selection looks only at the registered pending bits, so a capture in
    // this cycle becomes eligible on the next one.
    prio_enc8 u_prio_enc8 (
        .data_in (pending_q),
        .idx_out (enc_idx),
        .any     (enc_any)
    );

    // Edge detect against the previous req sample; req_q tracks req even when
    // capture is disabled, so enabling with req already high is not an edge.
    always_comb begin
        req_d = bus.req;
        ev    = EDGE ? (bus.req & ~req_q) : bus.req;
        cap   = bus.en ? ev : '0;
    end

    // Slot FSM next state: fill when something is pending, empty after a
    // handshake only when nothing is left to reload.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enc_any) state_d = HOLD;
            HOLD: if (bus.ready && !enc_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load/clear/merge datapath: a load clears its bit before new captures are
    // ORed in, so an edge on the bit being delivered counts as a fresh event.
    always_comb begin
        load      = enc_any && ((state_q == IDLE) || bus.ready);
        load_mask = load ? onehot_of(enc_idx) : '0;
        idx_d     = load ? enc_idx : idx_q;
        pending_d = (pending_q & ~load_mask) | cap;
        drop_d    = |(cap & pending_q & ~load_mask);
    end

    // State register with asynchronous clear of every flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            idx_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.valid   = (state_q == HOLD);
    assign bus.idx     = idx_q;
    assign bus.pending = pending_q;
    assign bus.drop    = drop_q;

endmodule

// File: tb/tb_irq_capture8.sv
// Directed bench for irq_capture8: stimulus pushes the indices it expects
// into a queue, and an independent monitor pops and compares each delivered
// index on every valid/ready handshake.
module tb_irq_capture8;
    import irq_pkg::*;

    logic clk;
    logic rst;

    int unsigned checks;
    int unsigned failures;

    logic [IDX_W-1:0] expq[$];

    irq_capture8_if bus ();

    irq_capture8 #(.EDGE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the request-side inputs of the interface.
    task automatic applyStimulus(input logic [N-1:0] req, input logic en, input logic ready);
        bus.req   = req;
        bus.en    = en;
        bus.ready = ready;
    endtask

    // Advance to just after the next active edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: inputs and outputs are stable at the negedge, so a valid&ready
    // seen here is the handshake that the next posedge completes.
    always @(negedge clk) begin
        if (!rst && bus.valid && bus.ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_delivery: got idx %0d, expected none at %0t", bus.idx, $time);
            end else begin
                logic [IDX_W-1:0] e;
                e = expq.pop_front();
                checkOutput("delivered_idx", 32'(bus.idx), 32'(e));
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(2);

        // Reset state
        checkOutput("reset_valid", 32'(bus.valid), 32'd0);
        checkOutput("reset_idx", 32'(bus.idx), 32'd0);
        checkOutput("reset_pending", 32'(bus.pending), 32'd0);
        checkOutput("reset_drop", 32'(bus.drop), 32'd0);
        rst = 1'b0;
        tick(1);

        // Test 1: single pulse on bit 2
        expq.push_back(3'd2);
        applyStimulus(8'h04, 1'b1, 1'b1);
        tick(1);
        checkOutput("t1_pending_set", 32'(bus.pending), 32'h04);
        checkOutput("t1_valid_not_yet", 32'(bus.valid), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(1);
        checkOutput("t1_valid", 32'(bus.valid), 32'd1);
        checkOutput("t1_idx", 32'(bus.idx), 32'd2);
        checkOutput("t1_pending_cleared", 32'(bus.pending), 32'h00);
        tick(1);
        checkOutput("t1_valid_gone", 32'(bus.valid), 32'd0);

        // Test 2: two simultaneous edges, held then drained back to back
        expq.push_back(3'd7);
        expq.push_back(3'd0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        tick(2);
        checkOutput("t2_valid", 32'(bus.valid), 32'd1);
        checkOutput("t2_idx", 32'(bus.idx), 32'd7);
        checkOutput("t2_pending", 32'(bus.pending), 32'h01);
        tick(2);
        checkOutput("t2_idx_stable", 32'(bus.idx), 32'd7);
        applyStimulus(8'h81, 1'b1, 1'b1);
        tick(1);
        checkOutput("t2_reload_valid", 32'(bus.valid), 32'd1);
        checkOutput("t2_reload_idx", 32'(bus.idx), 32'd0);
        tick(1);
        checkOutput("t2_drained", 32'(bus.valid), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(1);

        // Test 3: capture disabled, then enable with a request already high
        for (int i = 0; i < N; i++) begin
            applyStimulus(N'(1) << i, 1'b0, 1'b1);
            tick(1);
            applyStimulus(8'h00, 1'b0, 1'b1);
            tick(1);
            checkOutput("t3_pending_disabled", 32'(bus.pending), 32'h00);
        end
        checkOutput("t3_valid_disabled", 32'(bus.valid), 32'd0);
        applyStimulus(8'h10, 1'b0, 1'b1);
        tick(1);
        applyStimulus(8'h10, 1'b1, 1'b1);
        tick(2);
        checkOutput("t3_enable_no_event", 32'(bus.pending), 32'h00);
        checkOutput("t3_enable_no_valid", 32'(bus.valid), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(1);

        // Test 4: re-pulse a bit that is already pending
        expq.push_back(3'd7);
        expq.push_back(3'd3);
        applyStimulus(8'h88, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        checkOutput("t4_pending_bit3", 32'(bus.pending), 32'h08);
        checkOutput("t4_no_drop_yet", 32'(bus.drop), 32'd0);
        applyStimulus(8'h08, 1'b1, 1'b0);
        tick(1);
        checkOutput("t4_drop_pulse", 32'(bus.drop), 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        checkOutput("t4_drop_one_cycle", 32'(bus.drop), 32'd0);
        checkOutput("t4_pending_merged", 32'(bus.pending), 32'h08);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(4);
        checkOutput("t4_drained", 32'(bus.valid), 32'd0);

        // Test 5: new edge on the delivered bit during its handshake
        expq.push_back(3'd5);
        expq.push_back(3'd5);
        applyStimulus(8'h20, 1'b1, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(1);
        checkOutput("t5_hold_idx", 32'(bus.idx), 32'd5);
        applyStimulus(8'h20, 1'b1, 1'b1);
        tick(1);
        checkOutput("t5_no_drop", 32'(bus.drop), 32'd0);
        checkOutput("t5_repending", 32'(bus.pending), 32'h20);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(1);
        checkOutput("t5_second_valid", 32'(bus.valid), 32'd1);
        checkOutput("t5_second_idx", 32'(bus.idx), 32'd5);
        tick(2);
        checkOutput("t5_drained", 32'(bus.valid), 32'd0);

        // Test 6: asynchronous reset while holding with work pending
        applyStimulus(8'h7C, 1'b1, 1'b0);
        tick(1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(1);
        checkOutput("t6_pre_valid", 32'(bus.valid), 32'd1);
        checkOutput("t6_pre_idx", 32'(bus.idx), 32'd6);
        checkOutput("t6_pre_pending", 32'(bus.pending), 32'h3C);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(bus.valid), 32'd0);
        checkOutput("t6_async_idx", 32'(bus.idx), 32'd0);
        checkOutput("t6_async_pending", 32'(bus.pending), 32'h00);
        tick(1);
        rst = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick(3);

        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
        checkOutput("final_valid", 32'(bus.valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
